// File: rtl/pim_pkg.sv
// Shared types and defaults for the PIM partial-sum accumulator slice.
package pim_pkg;

  localparam int PSUM_W_DEF = 18;
  localparam int ADDR_W_DEF = 5;
  localparam int ACC_W_DEF  = 24;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {ACC_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pim_psum_accumulator_if.sv
// PIM macro bus plus result handshake; master is the accumulator side.
interface pim_psum_accumulator_if #(
  parameter int PSUM_W = 18,
  parameter int ADDR_W = 5,
  parameter int ACC_W  = 24
);
  logic [ADDR_W-1:0] pim_addr;
  logic              pim_en;
  logic [PSUM_W-1:0] pim_data;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;

  modport master (
    output pim_addr, pim_en, acc_out, out_valid, overflow,
    input  pim_data, out_ready
  );

  modport slave (
    input  pim_addr, pim_en, acc_out, out_valid, overflow,
    output pim_data, out_ready
  );
endinterface

// File: rtl/pim_psum_accumulator_lat_tracker.sv
// Delays the compute-enable by the macro latency so the accumulator knows
// which cycles carry a real partial sum.
module pim_lat_tracker #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic ret_valid
);

  logic [LAT-1:0] pipe_r;

  // enable shift register; reset drops anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_r <= {LAT{1'b0}};
    end else begin
      pipe_r[0] <= en;
      for (int i = 1; i < LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign ret_valid = pipe_r[LAT-1];

endmodule

// File: rtl/pim_psum_accumulator.sv
// Sweeps PIM rows, accumulates returned partial sums with saturation and
// hands the result over a valid/ready port.
module pim_psum_accumulator
  import pim_pkg::*;
#(
  parameter int PSUM_W  = PSUM_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PIM_LAT = 1,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     num_rows,
  output logic                busy,
  pim_psum_accumulator_if.master bus
);

  localparam logic [ADDR_W:0]   ONE_ROW  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   NO_ROWS  = {(ADDR_W+1){1'b0}};
  localparam logic [ACC_W-1:0]  ACC_SAT  = {ACC_W{1'b1}};

  state_t            state_r, next_state_s;
  logic [ADDR_W:0]   rows_r;
  logic [ADDR_W:0]   ret_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ACC_W-1:0]  acc_r;
  logic              overflow_r, pim_en_r, busy_r, out_valid_r;
  logic              ret_valid_s, accept_s, last_issue_s, last_ret_s;
  logic [ACC_W:0]    sum_s;

  // carry-out of the widened add flags saturation
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [PSUM_W-1:0] data);
    logic [ACC_W:0] wide;
    wide = {1'b0, acc} + {{(ACC_W+1-PSUM_W){1'b0}}, data};
    if (wide[ACC_W]) begin
      return {1'b1, ACC_SAT};
    end
    return wide;
  endfunction

  pim_lat_tracker #(.LAT(PIM_LAT)) u_lat (
    .clk       (clk),
    .reset     (reset),
    .en        (pim_en_r),
    .ret_valid (ret_valid_s)
  );

  assign accept_s     = ret_valid_s && (state_r == ST_ISSUE || state_r == ST_DRAIN);
  assign last_issue_s = ({1'b0, addr_r} == (rows_r - ONE_ROW));
  assign last_ret_s   = accept_s && ((ret_cnt_r + ONE_ROW) == rows_r);
  assign sum_s        = sat_add(acc_r, bus.pim_data);

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = (num_rows == NO_ROWS) ? ST_DONE : ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (last_issue_s) next_state_s = ST_DRAIN;
        else              next_state_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (last_ret_s) next_state_s = ST_DONE;
        else            next_state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (bus.out_ready) next_state_s = ST_IDLE;
        else               next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rows_r      <= NO_ROWS;
      ret_cnt_r   <= NO_ROWS;
      addr_r      <= {ADDR_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      overflow_r  <= 1'b0;
      pim_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      pim_en_r    <= (next_state_s == ST_ISSUE);
      busy_r      <= (next_state_s == ST_ISSUE) || (next_state_s == ST_DRAIN);
      out_valid_r <= (next_state_s == ST_DONE);
      if (state_r == ST_IDLE && start) begin
        rows_r     <= num_rows;
        ret_cnt_r  <= NO_ROWS;
        addr_r     <= {ADDR_W{1'b0}};
        acc_r      <= {ACC_W{1'b0}};
        overflow_r <= 1'b0;
      end else begin
        // address stops at the last row so a full sweep never wraps
        if (state_r == ST_ISSUE && !last_issue_s) begin
          addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        if (accept_s) begin
          acc_r      <= sum_s[ACC_W-1:0];
          overflow_r <= overflow_r | sum_s[ACC_W];
          ret_cnt_r  <= ret_cnt_r + ONE_ROW;
        end
      end
    end
  end

  assign busy          = busy_r;
  assign bus.pim_en    = pim_en_r;
  assign bus.pim_addr  = addr_r;
  assign bus.acc_out   = acc_r;
  assign bus.out_valid = out_valid_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_pim_psum_accumulator.sv
// Directed bench: instance A (latency 1, 24-bit acc), instance B (latency 3, 20-bit acc).
module tb_pim_psum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       rst_a, start_a, busy_a;
  logic [5:0] rows_a;
  logic       rst_b, start_b, busy_b;
  logic [5:0] rows_b;

  pim_psum_accumulator_if #(.PSUM_W(18), .ADDR_W(5), .ACC_W(24)) if_a ();
  pim_psum_accumulator_if #(.PSUM_W(18), .ADDR_W(5), .ACC_W(20)) if_b ();

  pim_psum_accumulator #(.PSUM_W(18), .ADDR_W(5), .PIM_LAT(1), .ACC_W(24)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .num_rows(rows_a), .busy(busy_a), .bus(if_a)
  );
  pim_psum_accumulator #(.PSUM_W(18), .ADDR_W(5), .PIM_LAT(3), .ACC_W(20)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .num_rows(rows_b), .busy(busy_b), .bus(if_b)
  );

  // PIM macro models: data for a row returns PIM_LAT cycles after its enable
  logic [17:0] mem_a [32];
  logic [17:0] mem_b [32];
  logic        pv_a = 1'b0;
  logic [4:0]  pa_a = 5'd0;
  logic [2:0]  pv_b = 3'd0;
  logic [4:0]  pa_b [3];

  always @(posedge clk) begin
    pv_a    <= if_a.pim_en;
    pa_a    <= if_a.pim_addr;
    pv_b    <= {pv_b[1:0], if_b.pim_en};
    pa_b[0] <= if_b.pim_addr;
    pa_b[1] <= pa_b[0];
    pa_b[2] <= pa_b[1];
  end

  assign if_a.pim_data = pv_a    ? mem_a[pa_a]    : 18'h2AAAA;
  assign if_b.pim_data = pv_b[2] ? mem_b[pa_b[2]] : 18'h2AAAA;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0; rows_a = 6'd0; rows_b = 6'd0;
    if_a.out_ready = 1'b0; if_b.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin mem_a[i] = 18'd0; mem_b[i] = 18'd0; end
    pa_b[0] = 5'd0; pa_b[1] = 5'd0; pa_b[2] = 5'd0;
    step(); step();
    n_cmp++; if ({busy_a, if_a.pim_en, if_a.out_valid, if_a.overflow} !== 4'b0000) begin
      n_err++; $display("FAIL reset_a_flags: got %b want 0000", {busy_a, if_a.pim_en, if_a.out_valid, if_a.overflow}); end
    n_cmp++; if (if_a.pim_addr !== 5'd0 || if_a.acc_out !== 24'd0) begin
      n_err++; $display("FAIL reset_a_data: addr %0d acc %0d want 0 0", if_a.pim_addr, if_a.acc_out); end
    n_cmp++; if ({busy_b, if_b.pim_en, if_b.out_valid, if_b.overflow} !== 4'b0000) begin
      n_err++; $display("FAIL reset_b_flags: got %b want 0000", {busy_b, if_b.pim_en, if_b.out_valid, if_b.overflow}); end
    rst_a = 1'b0; rst_b = 1'b0;
    step();
  endtask

  task automatic test_basic();
    mem_a[0] = 18'd10; mem_a[1] = 18'd20; mem_a[2] = 18'd30; mem_a[3] = 18'd40;
    start_a = 1'b1; rows_a = 6'd4;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (if_a.pim_en !== 1'b1 || if_a.pim_addr !== 5'(c) || busy_a !== 1'b1) begin
        n_err++; $display("FAIL basic_issue cyc%0d: en %b addr %0d busy %b want 1 %0d 1", c+1, if_a.pim_en, if_a.pim_addr, busy_a, c); end
      step();
    end
    n_cmp++; if (if_a.pim_en !== 1'b0 || if_a.pim_addr !== 5'd3 || if_a.out_valid !== 1'b0 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL basic_drain: en %b addr %0d valid %b busy %b want 0 3 0 1", if_a.pim_en, if_a.pim_addr, if_a.out_valid, busy_a); end
    step();
    n_cmp++; if (if_a.out_valid !== 1'b1 || if_a.acc_out !== 24'd100 || if_a.overflow !== 1'b0 || busy_a !== 1'b0) begin
      n_err++; $display("FAIL basic_result: valid %b acc %0d ovf %b busy %b want 1 100 0 0", if_a.out_valid, if_a.acc_out, if_a.overflow, busy_a); end
    if_a.out_ready = 1'b1;
    step();
    if_a.out_ready = 1'b0;
    n_cmp++; if (if_a.out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_handshake: valid %b want 0", if_a.out_valid); end
  endtask

  task automatic test_full_sweep();
    for (int i = 0; i < 32; i++) mem_a[i] = 18'h3FFFF;
    start_a = 1'b1; rows_a = 6'd32;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 32; c++) begin
      n_cmp++; if (if_a.pim_en !== 1'b1 || if_a.pim_addr !== 5'(c)) begin
        n_err++; $display("FAIL full_issue cyc%0d: en %b addr %0d want 1 %0d", c+1, if_a.pim_en, if_a.pim_addr, c); end
      step();
    end
    n_cmp++; if (if_a.pim_en !== 1'b0 || if_a.pim_addr !== 5'd31) begin
      n_err++; $display("FAIL full_nowrap: en %b addr %0d want 0 31", if_a.pim_en, if_a.pim_addr); end
    step();
    n_cmp++; if (if_a.out_valid !== 1'b1 || if_a.acc_out !== 24'd8388576 || if_a.overflow !== 1'b0) begin
      n_err++; $display("FAIL full_result: valid %b acc %0d ovf %b want 1 8388576 0", if_a.out_valid, if_a.acc_out, if_a.overflow); end
    if_a.out_ready = 1'b1;
    step();
    if_a.out_ready = 1'b0;
  endtask

  task automatic test_zero_rows();
    start_a = 1'b1; rows_a = 6'd0;
    step();
    start_a = 1'b0;
    n_cmp++; if (if_a.out_valid !== 1'b1 || if_a.acc_out !== 24'd0 || if_a.overflow !== 1'b0) begin
      n_err++; $display("FAIL zero_result: valid %b acc %0d ovf %b want 1 0 0", if_a.out_valid, if_a.acc_out, if_a.overflow); end
    n_cmp++; if (if_a.pim_en !== 1'b0 || busy_a !== 1'b0) begin
      n_err++; $display("FAIL zero_idle: en %b busy %b want 0 0", if_a.pim_en, busy_a); end
    if_a.out_ready = 1'b1;
    step();
    if_a.out_ready = 1'b0;
    n_cmp++; if (if_a.out_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_handshake: valid %b want 0", if_a.out_valid); end
  endtask

  task automatic test_back_to_back_hold();
    mem_a[0] = 18'd5; mem_a[1] = 18'd6;
    start_a = 1'b1; rows_a = 6'd2;
    step();
    start_a = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      start_a = 1'b1; rows_a = 6'd3;
      step();
      n_cmp++; if (if_a.out_valid !== 1'b1 || if_a.acc_out !== 24'd11 || busy_a !== 1'b0 || if_a.pim_en !== 1'b0) begin
        n_err++; $display("FAIL hold_stable i%0d: valid %b acc %0d busy %b en %b want 1 11 0 0", i, if_a.out_valid, if_a.acc_out, busy_a, if_a.pim_en); end
    end
    if_a.out_ready = 1'b1;
    step();
    n_cmp++; if (if_a.out_valid !== 1'b0 || busy_a !== 1'b0 || if_a.pim_en !== 1'b0) begin
      n_err++; $display("FAIL hold_release: valid %b busy %b en %b want 0 0 0", if_a.out_valid, busy_a, if_a.pim_en); end
    rows_a = 6'd1;
    step();
    start_a = 1'b0;
    n_cmp++; if (if_a.pim_en !== 1'b1 || busy_a !== 1'b1 || if_a.pim_addr !== 5'd0) begin
      n_err++; $display("FAIL hold_restart: en %b busy %b addr %0d want 1 1 0", if_a.pim_en, busy_a, if_a.pim_addr); end
    step(); step();
    n_cmp++; if (if_a.out_valid !== 1'b1 || if_a.acc_out !== 24'd5) begin
      n_err++; $display("FAIL hold_second: valid %b acc %0d want 1 5", if_a.out_valid, if_a.acc_out); end
    step();
    if_a.out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    int cyc;
    for (int i = 0; i < 32; i++) mem_b[i] = 18'h3FFFF;
    start_b = 1'b1; rows_b = 6'd8;
    step();
    start_b = 1'b0;
    cyc = 1;
    while (if_b.out_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
    n_cmp++; if (cyc != 12) begin
      n_err++; $display("FAIL sat_latency: valid seen in cycle %0d want 12", cyc); end
    n_cmp++; if (if_b.acc_out !== 20'hFFFFF || if_b.overflow !== 1'b1) begin
      n_err++; $display("FAIL sat_result: acc %0d ovf %b want 1048575 1", if_b.acc_out, if_b.overflow); end
    if_b.out_ready = 1'b1;
    step();
    if_b.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    int cyc;
    for (int i = 0; i < 32; i++) mem_b[i] = 18'd100;
    mem_b[0] = 18'd7; mem_b[1] = 18'd9;
    start_b = 1'b1; rows_b = 6'd16;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (if_b.pim_addr !== 5'd6 || if_b.acc_out !== 20'd116) begin
      n_err++; $display("FAIL mid_progress: addr %0d acc %0d want 6 116", if_b.pim_addr, if_b.acc_out); end
    rst_b = 1'b1;
    #1;
    n_cmp++; if ({busy_b, if_b.pim_en, if_b.out_valid, if_b.overflow} !== 4'b0000 || if_b.pim_addr !== 5'd0 || if_b.acc_out !== 20'd0) begin
      n_err++; $display("FAIL mid_reset: flags %b addr %0d acc %0d want 0000 0 0", {busy_b, if_b.pim_en, if_b.out_valid, if_b.overflow}, if_b.pim_addr, if_b.acc_out); end
    @(posedge clk); #1;
    rst_b = 1'b0;
    start_b = 1'b1; rows_b = 6'd2;
    step();
    start_b = 1'b0;
    cyc = 1;
    while (if_b.out_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
    n_cmp++; if (cyc != 6) begin
      n_err++; $display("FAIL mid_latency: valid seen in cycle %0d want 6", cyc); end
    n_cmp++; if (if_b.acc_out !== 20'd16 || if_b.overflow !== 1'b0) begin
      n_err++; $display("FAIL mid_result: acc %0d ovf %b want 16 0", if_b.acc_out, if_b.overflow); end
    if_b.out_ready = 1'b1;
    step();
    if_b.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_sweep();
    test_zero_rows();
    test_back_to_back_hold();
    test_saturate();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pim_psum_accumulator.md
Name: pim_psum_accumulator

Overview:
- Downstream sequencer/accumulator for the vecmat32 PIM macro.
- Sweeps the macro's row address over a programmed row count and accumulates the 18-bit merged partial sums into a wider saturating accumulator.
- Presents the final dot-product result through a valid/ready handshake to the attention datapath.
- Sits between the vecmat PIM stage (drives its address/compute-enable, consumes its data output) and the attention score/softmax logic.

Parameters:
PSUM_W, 18, width of the partial sum returned by the PIM macro (unsigned)
ADDR_W, 5, PIM row address width
PIM_LAT, 1, cycles from pim_en/pim_addr asserted to matching pim_data valid (1..4)
ACC_W, 24, accumulator/result width (ACC_W >= PSUM_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a sweep; honoured only in IDLE
num_rows  input  ADDR_W+1  rows to sweep, sampled with start; 0..2^ADDR_W
busy  output  1  high in ISSUE and DRAIN
pim_addr  output  ADDR_W  row address to PIM macro
pim_en  output  1  compute flag to PIM macro
pim_data  input  PSUM_W  partial sum from PIM macro
acc_out  output  ACC_W  accumulated result, stable while out_valid
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
overflow  output  1  sticky saturation flag for current result, valid with out_valid

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, pim_en=0, pim_addr=0, acc_out=0, out_valid=0, overflow=0; latency tracker and issue/return counters cleared. Data arriving after reset is ignored.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1, num_rows>=1: latch num_rows, clear acc and overflow, go to ISSUE.
- IDLE, start=1, num_rows=0: go to DONE with acc_out=0, overflow=0.
- start in any other state: ignored, no queuing.
- ISSUE: pim_en=1 every cycle. pim_addr = 0,1,...,num_rows-1, one per cycle. Leave to DRAIN after the cycle that issues num_rows-1. For num_rows=2^ADDR_W the address reaches all-ones and does not wrap into a re-issue.
- Return tracking: PIM_LAT-deep shift register of pim_en. When its tail is 1, pim_data is added on that clock edge.
- Accumulate: acc <= acc + zero-extended pim_data, saturating at 2^ACC_W-1. Any saturation sets overflow, which stays set until the next start.
- DRAIN: pim_en=0, pim_addr holds its last value. Go to DONE on the edge that accumulates return number num_rows.
- DONE: out_valid=1; acc_out and overflow held stable. When out_valid&&out_ready, go to IDLE on that edge, so out_valid is low the next cycle. A start in the same cycle as the handshake is ignored.
- Timing (start sampled on edge 0, N=num_rows>=1, L=PIM_LAT):
  - pim_en high in cycles 1..N.
  - Data for the address issued in cycle k is accumulated at the end of cycle k+L.
  - out_valid rises in cycle N+L+1.
  - Minimum start-to-start period is N+L+2 cycles with out_ready held high.
- pim_data outside return cycles: ignored (may be X).

Decomposition:
- Shared package pim_pkg: state encoding localparams (IDLE/ISSUE/DRAIN/DONE), default PSUM_W/ADDR_W/ACC_W, a saturating-add constant (ACC_MAX).
- One natural sub-module: pim_lat_tracker, a parameterised PIM_LAT-deep valid shift register with async reset. It outputs ret_valid.
- Accumulator and FSM stay in the top module.

Test Plan:
- Reset then start, num_rows=4, PIM_LAT=1, pim_data = 10,20,30,40 per addr 0..3 -> pim_addr 0,1,2,3 in cycles 1..4; out_valid in cycle 6; acc_out=100; overflow=0.
- num_rows=32, pim_data=2^18-1 every return, ACC_W=24 -> acc_out=32*262143=8388576 (no saturation); pim_addr covers 0..31 with no wrap; overflow=0.
- ACC_W=20, num_rows=8, pim_data=2^18-1 -> acc_out=2^20-1 saturated; overflow=1.
- num_rows=0 start -> out_valid next cycle, acc_out=0, pim_en never asserted.
- Hold out_ready=0 for 5 cycles in DONE while pulsing start -> acc_out/out_valid stable, start ignored. Then out_ready=1 -> out_valid=0 next cycle; new start accepted after.
- Assert reset in the middle of ISSUE (num_rows=16, PIM_LAT=3, after addr 5) -> all outputs 0 immediately. In-flight pim_data is not accumulated. A following sweep of num_rows=2 with data 7,9 yields acc_out=16.
